fifo_read_arbiter: RTL and testbench

Read-side scheduler for the async FIFO. It shares the single FIFO read port among several consumers using round-robin bursts. It sits in the read clock domain between the consumers and the read pointer/empty logic: it drives that logic's read increment, watches its empty flag, and returns each popped word, tagged with its owner, to the consumers.

---
 rtl/fifo_read_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst scheduler sharing one async-FIFO read port; option FIFO_ARB_FIXED_PRIORITY_EN.
// Latency: request->grant 1 cycle, pop in grant cycle, tagged data 1 cycle after pop.
// Backpressure: pops only while owner requests and FIFO is non-empty; bursts end after burst_max words.
module fifo_read_arbiter #(
    parameter int num_requesters = 4,
    parameter int data_size      = 8,
    parameter int burst_max      = 4
) (
    input  logic                      read_clk_i,
    input  logic                      read_reset_n_i,
    input  logic [num_requesters-1:0] request_i,
    input  logic                      read_empty_i,
    input  logic [data_size-1:0]      read_data_i,
    output logic                      read_increment_o,
    output logic [num_requesters-1:0] grant_o,
    output logic [data_size-1:0]      data_o,
    output logic [num_requesters-1:0] data_valid_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(burst_max) + 1;
    localparam int IDX_W = $clog2(num_requesters);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(burst_max - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                    r_state, w_state_nxt;
    logic [num_requesters-1:0] r_grant, w_grant_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [data_size-1:0]      r_data;
    logic [num_requesters-1:0] r_dv;
    logic [IDX_W-1:0]          w_winner;
    logic                      w_found;
    logic                      w_owner_req;
    logic                      w_pop;
    logic                      w_exit;

`ifdef FIFO_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = num_requesters - 1; i >= 0; i--) begin
            if (request_i[i]) begin
                w_winner = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] r_last, w_last_nxt;

    // Scan downward so the closest requester after r_last is assigned last and wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = num_requesters; i >= 1; i--) begin
            logic [IDX_W-1:0] v_idx;
            v_idx = IDX_W'((int'(r_last) + i) % num_requesters);
            if (request_i[v_idx]) begin
                w_winner = v_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            r_last <= IDX_W'(num_requesters - 1);
        end else begin
            r_last <= w_last_nxt;
        end
    end
`endif

    assign w_owner_req = |(r_grant & request_i);
    assign w_pop       = (r_state == ST_BURST) && w_owner_req && !read_empty_i;
    assign w_exit      = (w_pop && (r_cnt == CNT_LAST)) || !w_owner_req || read_empty_i;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
`ifndef FIFO_ARB_FIXED_PRIORITY_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (w_found && !read_empty_i) begin
                    w_state_nxt           = ST_BURST;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_cnt_nxt             = '0;
`ifndef FIFO_ARB_FIXED_PRIORITY_EN
                    w_last_nxt            = w_winner;
`endif
                end
            end
            ST_BURST: begin
                if (w_exit) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_pop) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_dv    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dv    <= w_pop ? r_grant : '0;
            if (w_pop) begin
                r_data <= read_data_i;
            end
        end
    end

    assign read_increment_o = w_pop;
    assign grant_o          = r_grant;
    assign data_o           = r_data;
    assign data_valid_o     = r_dv;
    assign busy_o           = (r_state == ST_BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter (4 requesters, 8-bit words, burst_max 4).
module tb_fifo_read_arbiter;

    logic       read_clk_i = 1'b0;
    logic       read_reset_n_i;
    logic [3:0] request_i;
    logic       read_empty_i;
    logic [7:0] read_data_i;
    logic       read_increment_o;
    logic [3:0] grant_o;
    logic [7:0] data_o;
    logic [3:0] data_valid_o;
    logic       busy_o;

    fifo_read_arbiter #(
        .num_requesters(4),
        .data_size     (8),
        .burst_max     (4)
    ) dut (
        .read_clk_i      (read_clk_i),
        .read_reset_n_i  (read_reset_n_i),
        .request_i       (request_i),
        .read_empty_i    (read_empty_i),
        .read_data_i     (read_data_i),
        .read_increment_o(read_increment_o),
        .grant_o         (grant_o),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .busy_o          (busy_o)
    );

    always #5 read_clk_i = ~read_clk_i;

    typedef struct {
        logic [3:0] req;
        logic       emp;
        logic [7:0] rd;
        logic       exp_inc;
        logic [3:0] exp_gnt;
        logic [3:0] exp_dv;
        logic [7:0] exp_dat;
        logic       exp_busy;
    } vec_t;

    vec_t       tbl[11];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q[$];
    logic [3:0] dv_rec[$];
    logic [7:0] dat_rec[$];
    logic [3:0] gnt_rec[$];
    int         b2b_err;
    int         empty_pop_err;
    logic [3:0] prev_gnt;
    logic [3:0] exp_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model FIFO drives empty/data from its contents, registered at each edge.
    task automatic settle();
        read_empty_i = (q.size() == 0);
        read_data_i  = (q.size() != 0) ? q[0] : 8'h00;
        #1;
    endtask

    task automatic advance();
        logic p;
        p = read_increment_o;
        if (p && read_empty_i) empty_pop_err++;
        if (grant_o != 4'b0 && prev_gnt != 4'b0 && grant_o != prev_gnt) b2b_err++;
        prev_gnt = grant_o;
        if (data_valid_o != 4'b0) begin
            dv_rec.push_back(data_valid_o);
            dat_rec.push_back(data_o);
        end
        if (p) gnt_rec.push_back(grant_o);
        @(posedge read_clk_i);
        #1;
        if (p && q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_reset();
        read_reset_n_i = 1'b0;
        request_i      = 4'b0;
        q.delete();
        dv_rec.delete();
        dat_rec.delete();
        gnt_rec.delete();
        b2b_err        = 0;
        empty_pop_err  = 0;
        prev_gnt       = 4'b0;
        @(posedge read_clk_i);
        #1;
        read_reset_n_i = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 8'hA0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 8'hA0, 1'b1, 4'b0001, 4'b0000, 8'h00, 1'b1};
        tbl[2]  = '{4'b0001, 1'b0, 8'hA1, 1'b1, 4'b0001, 4'b0001, 8'hA0, 1'b1};
        tbl[3]  = '{4'b0001, 1'b0, 8'hA2, 1'b1, 4'b0001, 4'b0001, 8'hA1, 1'b1};
        tbl[4]  = '{4'b0001, 1'b0, 8'hA3, 1'b1, 4'b0001, 4'b0001, 8'hA2, 1'b1};
        tbl[5]  = '{4'b0001, 1'b0, 8'hA4, 1'b0, 4'b0000, 4'b0001, 8'hA3, 1'b0};
        tbl[6]  = '{4'b0001, 1'b0, 8'hA4, 1'b1, 4'b0001, 4'b0000, 8'hA3, 1'b1};
        tbl[7]  = '{4'b0001, 1'b0, 8'hA5, 1'b1, 4'b0001, 4'b0001, 8'hA4, 1'b1};
        tbl[8]  = '{4'b0001, 1'b1, 8'hA5, 1'b0, 4'b0001, 4'b0001, 8'hA5, 1'b1};
        tbl[9]  = '{4'b0001, 1'b1, 8'hA5, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 8'hA5, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0};

        read_reset_n_i = 1'b0;
        request_i      = 4'b0;
        read_empty_i   = 1'b1;
        read_data_i    = 8'h00;
        repeat (2) @(posedge read_clk_i);
        #1;
        chk("rst grant", 32'(grant_o), 32'h0);
        chk("rst dv", 32'(data_valid_o), 32'h0);
        chk("rst data", 32'(data_o), 32'h0);
        chk("rst busy", 32'(busy_o), 32'h0);
        chk("rst inc", 32'(read_increment_o), 32'h0);
        read_reset_n_i = 1'b1;

        // Single requester, six words, burst of four then re-grant
        for (int r = 0; r < 11; r++) begin
            request_i    = tbl[r].req;
            read_empty_i = tbl[r].emp;
            read_data_i  = tbl[r].rd;
            #1;
            chk($sformatf("row%0d inc", r), 32'(read_increment_o), 32'(tbl[r].exp_inc));
            chk($sformatf("row%0d grant", r), 32'(grant_o), 32'(tbl[r].exp_gnt));
            chk($sformatf("row%0d dv", r), 32'(data_valid_o), 32'(tbl[r].exp_dv));
            chk($sformatf("row%0d data", r), 32'(data_o), 32'(tbl[r].exp_dat));
            chk($sformatf("row%0d busy", r), 32'(busy_o), 32'(tbl[r].exp_busy));
            @(posedge read_clk_i);
            #1;
        end

        // Two requesters, eight words
        do_reset();
        for (int k = 0; k < 8; k++) q.push_back(8'hB0 + 8'(k));
        request_i = 4'b0101;
        repeat (20) begin
            settle();
            advance();
        end
        settle();
        chk("rr pops", 32'(dv_rec.size()), 32'd8);
        for (int k = 0; k < 8 && k < dv_rec.size(); k++) begin
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
            exp_g = 4'b0001;
`else
            exp_g = (k < 4) ? 4'b0001 : 4'b0100;
`endif
            chk($sformatf("rr dv%0d", k), 32'(dv_rec[k]), 32'(exp_g));
            chk($sformatf("rr data%0d", k), 32'(dat_rec[k]), 32'(8'hB0 + 8'(k)));
        end
        chk("rr b2b grant", 32'(b2b_err), 32'd0);
        chk("rr empty pop", 32'(empty_pop_err), 32'd0);
        chk("rr end grant", 32'(grant_o), 32'h0);
        chk("rr end inc", 32'(read_increment_o), 32'h0);

        // Owner drops its request mid-burst, then reset lands mid-burst
        do_reset();
        for (int k = 0; k < 8; k++) q.push_back(8'hC0 + 8'(k));
        request_i = 4'b1010;
        settle();
        chk("drop c0 grant", 32'(grant_o), 32'h0);
        advance();
        settle();
        chk("drop c1 grant", 32'(grant_o), 32'h2);
        chk("drop c1 inc", 32'(read_increment_o), 32'h1);
        advance();
        settle();
        chk("drop c2 inc", 32'(read_increment_o), 32'h1);
        chk("drop c2 data", 32'(data_o), 32'hC0);
        advance();
        request_i = 4'b1000;
        settle();
        chk("drop c3 inc", 32'(read_increment_o), 32'h0);
        chk("drop c3 dv", 32'(data_valid_o), 32'h2);
        chk("drop c3 data", 32'(data_o), 32'hC1);
        advance();
        settle();
        chk("drop c4 grant", 32'(grant_o), 32'h0);
        chk("drop c4 busy", 32'(busy_o), 32'h0);
        chk("drop c4 dv", 32'(data_valid_o), 32'h0);
        chk("drop c4 data", 32'(data_o), 32'hC1);
        advance();
        settle();
        chk("drop c5 grant", 32'(grant_o), 32'h8);
        chk("drop c5 inc", 32'(read_increment_o), 32'h1);
        advance();
        settle();
        chk("drop c6 dv", 32'(data_valid_o), 32'h8);
        chk("drop c6 data", 32'(data_o), 32'hC2);
        read_reset_n_i = 1'b0;
        #1;
        chk("mid rst grant", 32'(grant_o), 32'h0);
        chk("mid rst dv", 32'(data_valid_o), 32'h0);
        chk("mid rst data", 32'(data_o), 32'h0);
        chk("mid rst busy", 32'(busy_o), 32'h0);
        chk("mid rst inc", 32'(read_increment_o), 32'h0);
        @(posedge read_clk_i);
        #1;
        chk("held rst inc", 32'(read_increment_o), 32'h0);
        chk("held rst grant", 32'(grant_o), 32'h0);

        // All requesting against an empty FIFO
        do_reset();
        request_i = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk($sformatf("empty c%0d grant", c), 32'(grant_o), 32'h0);
            chk($sformatf("empty c%0d inc", c), 32'(read_increment_o), 32'h0);
            advance();
        end

        // Requesters 1 and 2; fixed priority keeps requester 1
        do_reset();
        for (int k = 0; k < 8; k++) q.push_back(8'hD0 + 8'(k));
        request_i = 4'b0110;
        repeat (24) begin
            settle();
            advance();
        end
        chk("pri pops", 32'(gnt_rec.size()), 32'd8);
        for (int k = 0; k < 8 && k < gnt_rec.size(); k++) begin
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
            exp_g = 4'b0010;
`else
            exp_g = (k < 4) ? 4'b0010 : 4'b0100;
`endif
            chk($sformatf("pri grant%0d", k), 32'(gnt_rec[k]), 32'(exp_g));
        end
        chk("pri empty pop", 32'(empty_pop_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
